// File: rtl/wb_stage.sv
// Write-back stage: formats MEM/WB results, buffers them in a 2-entry skid
// FIFO and drives the register-file write port, ID/EX forwarding tap and
// retired-instruction counter.
module wb_stage #(
   parameter int unsigned SKID_DEPTH = 2,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_regwrite,
   input  logic             in_memtoreg,
   input  logic [31:0]      in_alu_result,
   input  logic [31:0]      in_mem_rdata,
   input  logic [1:0]       in_addr_lo,
   input  logic [1:0]       in_size,
   input  logic             in_unsigned,
   input  logic             rf_gnt,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [31:0]      fwd_data,
   output logic             align_err,
   output logic [CNT_W-1:0] retire_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef struct packed {
      logic              wr;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Only a depth of two is implemented (1-bit pointers, 3-state occupancy).
   if (SKID_DEPTH != 2) begin : g_bad_depth
      $error("wb_stage: SKID_DEPTH must be 2");
   end

   state_t            state_q, state_d;
   entry_t            mem_q [2];
   logic              head_q, tail_q;
   logic              head_valid;
   entry_t            head;
   entry_t            fmt_entry;
   logic              fmt_aligned;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic              push, pop;

   // Load lane select, extension and alignment check on the incoming entry.
   always_comb begin
      fmt_entry   = '0;
      fmt_aligned = 1'b1;
      load_data   = '0;
      byte_sel    = '0;
      case (in_addr_lo)
         2'd0:    byte_sel = in_mem_rdata[7:0];
         2'd1:    byte_sel = in_mem_rdata[15:8];
         2'd2:    byte_sel = in_mem_rdata[23:16];
         default: byte_sel = in_mem_rdata[31:24];
      endcase
      half_sel = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
      case (in_size)
         2'b00: load_data = in_unsigned ? {24'h0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
         2'b01: begin
            load_data   = in_unsigned ? {16'h0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
            fmt_aligned = ~in_addr_lo[0];
         end
         default: begin
            load_data   = in_mem_rdata;
            fmt_aligned = (in_addr_lo == 2'b00);
         end
      endcase
      if (!in_memtoreg) begin
         fmt_aligned = 1'b1;
      end
      fmt_entry.data = in_memtoreg ? load_data : in_alu_result;
      fmt_entry.rd   = in_rd;
      fmt_entry.wr   = in_regwrite & (in_rd != 5'd0) & fmt_aligned;
   end

   // Handshake events: a non-writing head retires without a grant.
   assign push = in_valid & in_ready;
   assign pop  = head_valid & (~head.wr | rf_gnt);

   // Occupancy state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Occupancy next state; simultaneous push and pop keeps the count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:    if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Outputs decoded from the registered state and the FIFO head.
   always_comb begin
      in_ready   = (state_q != FULL);
      head_valid = (state_q != EMPTY);
      head       = mem_q[head_q];
      rf_we      = head_valid & head.wr;
      rf_waddr   = head_valid ? head.rd   : '0;
      rf_wdata   = head_valid ? head.data : '0;
      fwd_valid  = rf_we;
      fwd_rd     = rf_waddr;
      fwd_data   = rf_wdata;
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
      end else begin
         if (push) begin
            mem_q[tail_q] <= fmt_entry;
            tail_q        <= ~tail_q;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
      end
   end

   // Misalignment pulse in the cycle after the push, and retire counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         align_err    <= 1'b0;
         retire_count <= '0;
      end else begin
         align_err <= push & in_memtoreg & ~fmt_aligned;
         if (pop) begin
            retire_count <= retire_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-entry vectors plus
// hand-written backpressure, non-writing and reset-mid-drain sequences.
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        in_memtoreg;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_rdata;
   logic [1:0]  in_addr_lo;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic        rf_gnt;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        align_err;
   logic [31:0] retire_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   wb_stage #(.SKID_DEPTH(2), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
      .in_addr_lo(in_addr_lo), .in_size(in_size), .in_unsigned(in_unsigned),
      .rf_gnt(rf_gnt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .align_err(align_err), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [1:0] lo, input logic [1:0] sz, input logic uns);
      in_valid = v; in_rd = rd; in_regwrite = rw; in_memtoreg = m2r;
      in_alu_result = alu; in_mem_rdata = rdata; in_addr_lo = lo;
      in_size = sz; in_unsigned = uns;
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [1:0]  lo;
      logic [1:0]  sz;
      logic        uns;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   localparam logic [31:0] MW = 32'h80FF7F01;
   vec_t vt [15];

   initial begin
      vt[0]  = '{5'd9,  1'b1, 1'b0, 32'h00000005, 2'd0, 2'd2, 1'b0, 1'b1, 32'h00000005, 1'b0};
      vt[1]  = '{5'd1,  1'b1, 1'b1, 32'h0,        2'd3, 2'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0};
      vt[2]  = '{5'd2,  1'b1, 1'b1, 32'h0,        2'd3, 2'd0, 1'b1, 1'b1, 32'h00000080, 1'b0};
      vt[3]  = '{5'd3,  1'b1, 1'b1, 32'h0,        2'd2, 2'd1, 1'b0, 1'b1, 32'hFFFF80FF, 1'b0};
      vt[4]  = '{5'd4,  1'b1, 1'b1, 32'h0,        2'd0, 2'd1, 1'b0, 1'b1, 32'h00007F01, 1'b0};
      vt[5]  = '{5'd6,  1'b1, 1'b1, 32'h0,        2'd1, 2'd0, 1'b0, 1'b1, 32'h0000007F, 1'b0};
      vt[6]  = '{5'd7,  1'b1, 1'b1, 32'h0,        2'd2, 2'd0, 1'b1, 1'b1, 32'h000000FF, 1'b0};
      vt[7]  = '{5'd8,  1'b1, 1'b1, 32'h0,        2'd2, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
      vt[8]  = '{5'd10, 1'b1, 1'b1, 32'h0,        2'd2, 2'd1, 1'b1, 1'b1, 32'h000080FF, 1'b0};
      vt[9]  = '{5'd11, 1'b1, 1'b1, 32'h0,        2'd0, 2'd2, 1'b0, 1'b1, 32'h80FF7F01, 1'b0};
      vt[10] = '{5'd12, 1'b1, 1'b1, 32'h0,        2'd0, 2'd3, 1'b0, 1'b1, 32'h80FF7F01, 1'b0};
      vt[11] = '{5'd13, 1'b1, 1'b1, 32'h0,        2'd2, 2'd2, 1'b0, 1'b0, 32'h0,        1'b1};
      vt[12] = '{5'd14, 1'b1, 1'b1, 32'h0,        2'd1, 2'd1, 1'b0, 1'b0, 32'h0,        1'b1};
      vt[13] = '{5'd15, 1'b1, 1'b0, 32'h12345678, 2'd3, 2'd1, 1'b0, 1'b1, 32'h12345678, 1'b0};
      vt[14] = '{5'd0,  1'b1, 1'b0, 32'hDEADBEEF, 2'd0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};

      // Reset held with a valid entry offered.
      reset = 1'b0;
      rf_gnt = 1'b1;
      drive(1'b1, vt[0].rd, vt[0].rw, vt[0].m2r, vt[0].alu, MW, vt[0].lo, vt[0].sz, vt[0].uns);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_align_err", 32'(align_err), 32'd0);
      chk("rst_retire", retire_count, 32'd0);
      reset = 1'b1;

      // Table: one entry per vector, granted, checked the cycle after push.
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, vt[i].rd, vt[i].rw, vt[i].m2r, vt[i].alu, MW, vt[i].lo, vt[i].sz, vt[i].uns);
         @(negedge clk);
         chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vt[i].exp_we));
         chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vt[i].exp_we));
         chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vt[i].rd));
         chk($sformatf("v%0d_fwd_rd", i), 32'(fwd_rd), 32'(vt[i].rd));
         if (!vt[i].exp_err) begin
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vt[i].exp_data);
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].exp_data);
         end
         chk($sformatf("v%0d_align_err", i), 32'(align_err), 32'(vt[i].exp_err));
         in_valid = 1'b0;
         exp_cnt++;
         @(negedge clk);
         chk($sformatf("v%0d_retire", i), retire_count, 32'(exp_cnt));
         chk($sformatf("v%0d_align_err_off", i), 32'(align_err), 32'd0);
         chk($sformatf("v%0d_drained", i), 32'(rf_we), 32'd0);
      end

      // Backpressure: three writes with no grant.
      rf_gnt = 1'b0;
      drive(1'b1, 5'd20, 1'b1, 1'b0, 32'h0000000A, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      chk("bp_ready_after1", 32'(in_ready), 32'd1);
      drive(1'b1, 5'd21, 1'b1, 1'b0, 32'h0000000B, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      chk("bp_ready_full", 32'(in_ready), 32'd0);
      drive(1'b1, 5'd22, 1'b1, 1'b0, 32'h0000000C, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_we", 32'(rf_we), 32'd1);
      chk("bp_hold_waddr", 32'(rf_waddr), 32'd20);
      chk("bp_hold_wdata", rf_wdata, 32'h0000000A);
      chk("bp_hold_retire", retire_count, 32'(exp_cnt));
      rf_gnt = 1'b1;
      @(negedge clk);
      chk("bp_second_waddr", 32'(rf_waddr), 32'd21);
      chk("bp_second_wdata", rf_wdata, 32'h0000000B);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_third_waddr", 32'(rf_waddr), 32'd22);
      chk("bp_third_wdata", rf_wdata, 32'h0000000C);
      @(negedge clk);
      exp_cnt += 3;
      chk("bp_empty_we", 32'(rf_we), 32'd0);
      chk("bp_retire", retire_count, 32'(exp_cnt));

      // $0 and non-writing entries retire without a grant.
      rf_gnt = 1'b0;
      drive(1'b1, 5'd0, 1'b1, 1'b0, 32'h11111111, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      chk("nw_r0_we", 32'(rf_we), 32'd0);
      chk("nw_r0_fwd", 32'(fwd_valid), 32'd0);
      drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h22222222, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("nw_r5_we", 32'(rf_we), 32'd0);
      chk("nw_r5_waddr", 32'(rf_waddr), 32'd5);
      @(negedge clk);
      exp_cnt += 2;
      chk("nw_retire", retire_count, 32'(exp_cnt));
      chk("nw_empty_waddr", 32'(rf_waddr), 32'd0);

      // Fill, drain one, then reset with one entry still buffered.
      drive(1'b1, 5'd25, 1'b1, 1'b0, 32'h000000D0, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd26, 1'b1, 1'b0, 32'h000000E0, MW, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      chk("rd_full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rf_gnt = 1'b1;
      @(negedge clk);
      exp_cnt++;
      chk("rd_second_waddr", 32'(rf_waddr), 32'd26);
      chk("rd_retire_pre", retire_count, 32'(exp_cnt));
      rf_gnt = 1'b0;
      reset = 1'b0;
      #1;
      chk("rd_async_we", 32'(rf_we), 32'd0);
      chk("rd_async_retire", retire_count, 32'd0);
      chk("rd_async_ready", 32'(in_ready), 32'd1);
      chk("rd_async_wdata", rf_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rf_gnt = 1'b1;
      @(negedge clk);
      chk("rd_after_we", 32'(rf_we), 32'd0);
      chk("rd_after_retire", retire_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the writer side of the register-file port that id_stage reads through reg1_data/reg2_data.
- Accepts MEM/WB results over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Formats load data, with byte/half lane select and sign/zero extension, before it is buffered.
- Drives a granted register-file write port, a forwarding tap for ID/EX, and a retired-instruction counter.

Parameters:
- SKID_DEPTH, 2, FIFO entries. Fixed at 2 in this revision; any other value is illegal.
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM/WB entry present
- in_ready  out  1  stage can accept the entry
- in_rd  in  5  destination register
- in_regwrite  in  1  instruction writes a register
- in_memtoreg  in  1  1 = use load data, 0 = use ALU result
- in_alu_result  in  32  ALU result
- in_mem_rdata  in  32  raw memory word, little-endian
- in_addr_lo  in  2  load address bits [1:0]
- in_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- in_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- rf_gnt  in  1  register file accepts the write this cycle
- rf_we  out  1  write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- fwd_valid  out  1  the head entry will write a register
- fwd_rd  out  5  head destination register
- fwd_data  out  32  head write data
- align_err  out  1  one-cycle pulse on a misaligned load
- retire_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset (async, reset=0): FIFO emptied, pointers and count = 0, retire_count = 0, align_err = 0.
  - Derived outputs at reset: in_ready = 1; rf_we, fwd_valid = 0; rf_waddr, fwd_rd = 0; rf_wdata, fwd_data = 0.
  - Reset asserted mid-operation discards any buffered entries; no partial write completes.
- FIFO occupancy states: EMPTY (0), ONE (1), FULL (2).
  - in_ready = (state != FULL). It is a registered function of state and never depends combinationally on rf_gnt.
  - Push on in_valid & in_ready at a clock edge.
  - Pop at a clock edge when the head is valid and either (a) it writes and rf_gnt = 1, or (b) it does not write. A non-writing head retires without a grant.
  - Simultaneous push and pop: count is unchanged, and the new entry goes to the tail.
  - Transitions: EMPTY→ONE on push only; ONE→FULL on push only; ONE→EMPTY on pop only; FULL→ONE on pop. No push is possible in FULL.
- Formatting is combinational on input signals and stored at push time.
  - Byte: lane = in_addr_lo.
  - Half: lane = in_addr_lo[1]. A half access requires in_addr_lo[0] = 0.
  - Word: requires in_addr_lo = 00.
  - Extension: sign-extend from bit 7 or bit 15, or zero-extend when in_unsigned = 1.
  - in_memtoreg = 0: data = in_alu_result, and size/alignment are ignored.
- Misaligned load (memtoreg = 1 and an alignment rule fails):
  - The entry is pushed with its write flag cleared.
  - align_err pulses high for the cycle after the push.
  - The entry still retires.
- Write flag = in_regwrite & (in_rd != 0) & aligned. Register $0 is never written.
- Output port, from the FIFO head (combinational from registered state):
  - rf_we = head valid & write flag; rf_waddr = head rd; rf_wdata = head data.
  - fwd_valid, fwd_rd and fwd_data equal rf_we, rf_waddr and rf_wdata.
  - All are zero when the FIFO is empty.
- Latency: an entry pushed at edge N appears on rf_* in cycle N+1. With rf_gnt held at 1, throughput is 1 entry per cycle.
- rf_gnt = 0 holds rf_we and the other rf_* outputs stable until the grant arrives.
- retire_count increments by 1 on every pop and wraps modulo 2^CNT_W.

Test Plan:
- Reset: hold reset = 0 with in_valid = 1 → in_ready = 1, rf_we = 0, retire_count = 0. Release reset → the first push appears on rf_* one cycle later.
- ALU writeback: rd = 9, alu = 0x00000005, regwrite = 1, memtoreg = 0, rf_gnt = 1 → the next cycle shows rf_we = 1, waddr = 9, wdata = 0x00000005; retire_count = 1.
- Load formatting with mem_rdata = 0x80FF7F01:
  - byte, addr_lo = 3, signed → 0xFFFFFF80
  - byte, addr_lo = 3, unsigned → 0x00000080
  - half, addr_lo = 2, signed → 0xFFFF80FF
  - half, addr_lo = 0, signed → 0x00007F01
- Backpressure: rf_gnt = 0 with three back-to-back writes → in_ready falls after 2 pushes and rf_* stay on entry 1. Raise rf_gnt → entries drain in order, in_ready returns, and all 3 retire.
- $0 and non-writing instructions: rd = 0 with regwrite = 1, and rd = 5 with regwrite = 0, both with rf_gnt = 0 → rf_we stays 0, both retire, and retire_count += 2.
- Misalignment plus reset: word load with addr_lo = 2 → align_err pulses once, no write, count += 1. Then fill the FIFO and assert reset mid-drain → rf_we = 0 immediately and count = 0.
